// File: rtl/fifo_serializer.sv
// Pulls words from a FIFO read port with an rts/rtr handshake and shifts each one out
// as a UART-like frame: start 0, data MSB first, stop 1, every bit held CLK_DIV clocks.
module fifo_serializer #(
   parameter int DATA_SIZE = 16,
   parameter int CLK_DIV   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] ser_inp_data,
   input  logic                 ser_inp_rts,
   output logic                 ser_inp_rtr,
   input  logic                 ser_en,
   output logic                 ser_out,
   output logic                 ser_frame,
   output logic                 ser_busy,
   output logic [7:0]           ser_word_count
);

   localparam int              BIT_W    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [7:0]           div_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_SIZE-1:0] shreg;
   logic [7:0]           word_count;
   logic                 bit_end;
   logic                 fetch;

   assign bit_end        = (div_cnt == DIV_LAST);
   assign fetch          = ser_en && ser_inp_rts;
   assign ser_word_count = word_count;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block is given a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_next  = state;
      ser_inp_rtr = 1'b0;
      ser_out     = 1'b1;
      ser_frame   = 1'b0;
      ser_busy    = (state != IDLE);

      case (state)
         IDLE: begin
            if (fetch) state_next = REQ;
         end
         REQ: begin
            // The read request is only ever offered here, so one word per frame at most.
            ser_inp_rtr = 1'b1;
            state_next  = ser_inp_rts ? LOAD : IDLE;
         end
         LOAD: begin
            state_next = START;
         end
         START: begin
            ser_out   = 1'b0;
            ser_frame = 1'b1;
            if (bit_end) state_next = DATA;
         end
         DATA: begin
            ser_out   = shreg[DATA_SIZE-1];
            ser_frame = 1'b1;
            if (bit_end && (bit_cnt == BIT_LAST)) state_next = STOP;
         end
         STOP: begin
            ser_frame = 1'b1;
            if (bit_end) state_next = fetch ? REQ : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // NOTE: the shift register is reset along with the counters so a dropped frame
   // leaves no stale data behind; it is a single word, not an array, so this is cheap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         word_count <= '0;
      end else begin
         // Counters restart on every state change; within DATA they roll per bit.
         if (state_next != state) begin
            div_cnt <= '0;
            bit_cnt <= '0;
         end else if (ser_frame) begin
            if (bit_end) begin
               div_cnt <= '0;
               bit_cnt <= bit_cnt + 1'b1;
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
         end

         if (state == LOAD) begin
            shreg <= ser_inp_data;
         end else if ((state == DATA) && bit_end) begin
            shreg <= shreg << 1;
         end

         if ((state == STOP) && bit_end) begin
            word_count <= word_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer: a queue-backed FIFO model feeds words and each
// frame on ser_out is compared bit by bit against hand-built start/data/stop patterns.
module tb_fifo_serializer;

   localparam int DATA_SIZE = 16;
   localparam int CLK_DIV   = 4;
   localparam int FRAME_BITS = DATA_SIZE + 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [DATA_SIZE-1:0] ser_inp_data = '0;
   logic                 ser_inp_rts = 1'b0;
   logic                 ser_inp_rtr;
   logic                 ser_en = 1'b0;
   logic                 ser_out;
   logic                 ser_frame;
   logic                 ser_busy;
   logic [7:0]           ser_word_count;

   int n_checks   = 0;
   int n_fail     = 0;
   int rtr_pulses = 0;
   logic [DATA_SIZE-1:0] fifo[$];

   fifo_serializer #(
      .DATA_SIZE(DATA_SIZE),
      .CLK_DIV  (CLK_DIV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ser_inp_data  (ser_inp_data),
      .ser_inp_rts   (ser_inp_rts),
      .ser_inp_rtr   (ser_inp_rtr),
      .ser_en        (ser_en),
      .ser_out       (ser_out),
      .ser_frame     (ser_frame),
      .ser_busy      (ser_busy),
      .ser_word_count(ser_word_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: FIFO model pops on a handshake edge and presents the word for the
   // following cycle only; any other cycle carries junk on the data bus.
   task automatic step();
      logic hs;
      hs = ser_inp_rtr && ser_inp_rts;
      if (ser_inp_rtr) rtr_pulses++;
      @(posedge clk);
      #1;
      if (hs && (fifo.size() != 0)) ser_inp_data = fifo.pop_front();
      else                          ser_inp_data = DATA_SIZE'($urandom);
      ser_inp_rts = (fifo.size() != 0);
   endtask

   task automatic push(input logic [DATA_SIZE-1:0] word);
      fifo.push_back(word);
      ser_inp_rts = 1'b1;
   endtask

   // Waits for the start bit (expecting exp_wait clocks of lead-in), then samples every
   // cycle of the frame; optionally drops ser_en at the first cycle of frame bit drop_bit.
   task automatic expect_frame(input logic [DATA_SIZE-1:0] word, input int exp_wait,
                               input int drop_bit, input string tag);
      int wait_n = 0;
      int bad = 0;
      int lead_bad = 0;
      logic [FRAME_BITS-1:0] got = '0;
      logic [FRAME_BITS-1:0] exp;
      exp = {1'b0, word, 1'b1};
      while ((ser_out !== 1'b0) && (wait_n < 20)) begin
         if (ser_frame !== 1'b0) lead_bad++;
         step();
         wait_n++;
      end
      check({tag, "_lead"}, 32'(wait_n), 32'(exp_wait));
      check({tag, "_lead_frame"}, 32'(lead_bad), 32'd0);
      for (int b = 0; b < FRAME_BITS; b++) begin
         if (b == drop_bit) ser_en = 1'b0;
         for (int c = 0; c < CLK_DIV; c++) begin
            if (c == 0) got[FRAME_BITS-1-b] = ser_out;
            else if (ser_out !== got[FRAME_BITS-1-b]) bad++;
            if (ser_frame !== 1'b1) bad++;
            step();
         end
      end
      check({tag, "_bits"}, 32'(got), 32'(exp));
      check({tag, "_stable"}, 32'(bad), 32'd0);
      check({tag, "_frame_end"}, 32'(ser_frame), 32'd0);
   endtask

   initial begin
      logic any_rtr;
      logic any_low;
      logic any_busy;
      logic done;
      int   max_cnt;

      // Reset state
      repeat (3) step();
      check("rst_out", 32'(ser_out), 32'd1);
      check("rst_rtr", 32'(ser_inp_rtr), 32'd0);
      check("rst_frame", 32'(ser_frame), 32'd0);
      check("rst_busy", 32'(ser_busy), 32'd0);
      check("rst_count", 32'(ser_word_count), 32'd0);
      rst = 1'b1;
      step();

      // Single word 0xA5C3: one rtr pulse, 18 bits of 4 clocks, count 1
      rtr_pulses = 0;
      ser_en = 1'b1;
      push(16'hA5C3);
      expect_frame(16'hA5C3, 3, -1, "single");
      check("single_rtr", 32'(rtr_pulses), 32'd1);
      check("single_count", 32'(ser_word_count), 32'd1);
      check("single_idle", 32'(ser_busy), 32'd0);

      // rts low with ser_en high: nothing happens
      any_rtr = 1'b0; any_low = 1'b0; any_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         any_rtr  |= ser_inp_rtr;
         any_low  |= ~ser_out;
         any_busy |= ser_busy;
      end
      check("norts_rtr", 32'(any_rtr), 32'd0);
      check("norts_out_low", 32'(any_low), 32'd0);
      check("norts_busy", 32'(any_busy), 32'd0);

      // ser_en low with a word waiting: stays idle
      rtr_pulses = 0;
      ser_en = 1'b0;
      push(16'hC0DE);
      any_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         any_busy |= ser_busy;
      end
      check("noen_busy", 32'(any_busy), 32'd0);
      check("noen_rtr", 32'(rtr_pulses), 32'd0);

      // REQ with rts withdrawn: back to IDLE, word still in the FIFO, then a retry
      ser_en = 1'b1;
      step();
      check("req_rtr", 32'(ser_inp_rtr), 32'd1);
      ser_inp_rts = 1'b0;
      ser_en = 1'b0;
      step();
      check("req_abort_busy", 32'(ser_busy), 32'd0);
      check("req_abort_fifo", 32'(fifo.size()), 32'd1);
      ser_en = 1'b1;
      expect_frame(16'hC0DE, 3, -1, "retry");
      check("retry_count", 32'(ser_word_count), 32'd2);

      // Three queued words back to back, two idle-high clocks between frames
      rtr_pulses = 0;
      push(16'h1234);
      push(16'hFFFF);
      push(16'h0001);
      expect_frame(16'h1234, 3, -1, "b2b0");
      expect_frame(16'hFFFF, 2, -1, "b2b1");
      expect_frame(16'h0001, 2, -1, "b2b2");
      check("b2b_rtr", 32'(rtr_pulses), 32'd3);
      check("b2b_count", 32'(ser_word_count), 32'd5);

      // ser_en dropped during data bit 5: frame completes, no further fetch
      rtr_pulses = 0;
      push(16'h8001);
      push(16'h7FFE);
      push(16'h3C3C);
      expect_frame(16'h8001, 3, 6, "endrop");
      any_rtr = 1'b0; any_busy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         any_rtr  |= ser_inp_rtr;
         any_busy |= ser_busy;
         step();
      end
      check("endrop_rtr_pulses", 32'(rtr_pulses), 32'd1);
      check("endrop_rtr_after", 32'(any_rtr), 32'd0);
      check("endrop_busy_after", 32'(any_busy), 32'd0);
      check("endrop_count", 32'(ser_word_count), 32'd6);
      ser_en = 1'b1;
      expect_frame(16'h7FFE, 3, -1, "resume0");
      expect_frame(16'h3C3C, 2, -1, "resume1");
      check("resume_count", 32'(ser_word_count), 32'd8);

      // Reset during data bit 8 (word bit 7 of 0x1234 is 0)
      push(16'h1234);
      begin
         int n = 0;
         while ((ser_out !== 1'b0) && (n < 20)) begin
            step();
            n++;
         end
         check("midrst_lead", 32'(n), 32'd3);
      end
      repeat (9 * CLK_DIV + 2) step();
      check("midrst_pre_out", 32'(ser_out), 32'd0);
      rst = 1'b0;
      #1;
      check("midrst_out", 32'(ser_out), 32'd1);
      check("midrst_frame", 32'(ser_frame), 32'd0);
      check("midrst_busy", 32'(ser_busy), 32'd0);
      check("midrst_count", 32'(ser_word_count), 32'd0);
      repeat (3) step();
      rst = 1'b1;
      step();
      push(16'h5A5A);
      expect_frame(16'h5A5A, 3, -1, "postrst");
      check("postrst_count", 32'(ser_word_count), 32'd1);

      // 256 frames from a fresh reset: count wraps 255 -> 0
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      rtr_pulses = 0;
      for (int i = 0; i < 256; i++) push(DATA_SIZE'(i * 257));
      done = 1'b0;
      max_cnt = 0;
      for (int i = 0; i < 256 * (FRAME_BITS * CLK_DIV + 2) + 50; i++) begin
         step();
         if (int'(ser_word_count) > max_cnt) max_cnt = int'(ser_word_count);
         if ((fifo.size() == 0) && !ser_busy) begin
            done = 1'b1;
            break;
         end
      end
      check("wrap_done", 32'(done), 32'd1);
      check("wrap_max", 32'(max_cnt), 32'd255);
      check("wrap_count", 32'(ser_word_count), 32'd0);
      check("wrap_rtr", 32'(rtr_pulses), 32'd256);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 Parameter DATA_SIZE, default 16, word width taken from the FIFO read side.
REQ-002 Parameter CLK_DIV, default 4, clocks per serial bit; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ser_inp_data  input  DATA_SIZE  word from FIFO read port; valid the cycle after a handshake edge.
REQ-006 ser_inp_rts  input  1  FIFO ready-to-send (FIFO not empty).
REQ-007 ser_inp_rtr  output  1  serializer ready-to-receive; drives FIFO read request.
REQ-008 ser_en  input  1  enables fetching of new words.
REQ-009 ser_out  output  1  serial line; idle level 1.
REQ-010 ser_frame  output  1  high while a frame (start, data, stop) is on ser_out.
REQ-011 ser_busy  output  1  high whenever state is not IDLE.
REQ-012 ser_word_count  output  8  count of completed frames, modulo 256.

Function
REQ-013 States SHALL be IDLE, REQ, LOAD, START, DATA, STOP.
REQ-014 IDLE -> REQ when ser_en=1 and ser_inp_rts=1 at a clock edge; otherwise stay IDLE.
REQ-015 ser_inp_rtr SHALL be 1 only in REQ, which lasts exactly one cycle.
REQ-016 A handshake SHALL occur on the REQ-cycle edge only when ser_inp_rtr=1 and ser_inp_rts=1; then REQ -> LOAD.
REQ-017 REQ with ser_inp_rts=0 SHALL return to IDLE with no word consumed.
REQ-018 LOAD SHALL capture ser_inp_data into a DATA_SIZE shift register and go to START after one cycle.
REQ-019 Frame SHALL be: start bit 0, DATA_SIZE data bits MSB first, stop bit 1; each bit held exactly CLK_DIV cycles.
REQ-020 ser_out SHALL be 1 in IDLE, REQ and LOAD.
REQ-021 Bit timing SHALL use an 8-bit divide counter and a bit index counter; both clear on every state entry.
REQ-022 DATA -> STOP after the last data bit; STOP lasts CLK_DIV cycles.
REQ-023 At end of STOP, ser_word_count SHALL increment; 255 wraps to 0.
REQ-024 At end of STOP: go to REQ if ser_en=1 and ser_inp_rts=1; otherwise go to IDLE.
REQ-025 Back-to-back frames SHALL therefore have exactly 2 idle-high cycles (REQ, LOAD) between stop bit and next start bit.
REQ-026 Latency: ser_out falls 3 edges after the first edge with ser_en=1 and ser_inp_rts=1 in IDLE.
REQ-027 Frame length SHALL be (DATA_SIZE+2)*CLK_DIV cycles; ser_frame high for exactly that span.
REQ-028 Deasserting ser_en mid-frame SHALL NOT abort the frame; it only blocks the next fetch.
REQ-029 ser_inp_data SHALL be ignored in every state except LOAD.
REQ-030 At most one word SHALL be consumed per frame; no handshake occurs while busy in LOAD, START, DATA or STOP.

Reset
REQ-031 rst=0 SHALL force IDLE asynchronously: ser_out=1, ser_inp_rtr=0, ser_frame=0, ser_busy=0, ser_word_count=0, counters and shift register 0.
REQ-032 Reset mid-frame SHALL drop the frame immediately with ser_out=1; the word is lost and is not counted.
REQ-033 After rst returns to 1, the first fetch SHALL follow REQ-014 timing.

Verification
REQ-034 Single word, CLK_DIV=4, word 0xA5C3, rts=1 for one word -> one rtr pulse; ser_out = 0,1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1,1 with each bit 4 cycles (72 cycles); ser_word_count=1.
REQ-035 Three words queued, ser_en=1 -> three frames, exactly 2 high cycles between each stop bit and the next start bit; ser_word_count=3.
REQ-036 ser_en dropped at data bit 5 of frame 1 with rts=1 -> frame 1 completes; no rtr pulse afterward; state IDLE.
REQ-037 rts=0 throughout with ser_en=1 -> ser_inp_rtr never 1; ser_out stays 1; ser_busy stays 0.
REQ-038 rst=0 asserted during data bit 8 -> same-cycle ser_out=1, ser_frame=0, count unchanged at 0; a new word after release gives a full frame.
REQ-039 256 single frames -> ser_word_count wraps to 0.
